seq_puzzle_master: RTL and testbench
====================================

Name: seq_puzzle_master

Overview:
- Drives the four-digit sequence-memory puzzle from the other side of the seven-segment sequence display.
- Generates a random 16-bit one-cold sequence and commands the display to show it by holding the display code at 8'h10.
- Shadows the player's button_move/button_next entry, compares the four entered digits against the sequence, and reports solved, strike or exploded to the game top level.

Parameters:
- LFSR_SEED, 16'hACE1, reset value of the sequence LFSR. A seed of 0 is forced to 16'h0001.
- SHOW_SECS, 2, number of one_sec pulses the sequence is shown before entry is armed.
- GUARD_CYCLES, 4, clk cycles waited after the show phase before button_next is accepted.
- MAX_STRIKES, 3, failed attempts that cause exploded.
- FIXED_SEQ, 16'hE7BD, sequence used when SEQ_DEBUG_FIXED_EN is defined.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins the puzzle.
- one_sec  in  1  single-cycle pulse, once per second.
- button_move  in  1  debounced single-cycle pulse.
- button_next  in  1  debounced single-cycle pulse.
- display  out  8  display command: 8'h10 = sequence puzzle active, 8'h00 = idle.
- sequence_gen  out  16  four one-cold nibbles; [15:12] is the first digit entered.
- solved  out  1  sticky; all four digits matched.
- exploded  out  1  sticky; strikes reached MAX_STRIKES.
- strikes  out  2  failed-attempt count.
- strike_pulse  out  1  one cycle per failed attempt.

Behaviour:
- Reset values: display 8'h00, sequence_gen 16'h0000, solved 0, exploded 0, strikes 0, strike_pulse 0, lfsr LFSR_SEED, state IDLE.
- LFSR:
  - 16-bit Galois, mask 16'hB400, advances every cycle in every state.
  - Digit mapping: nibble k comes from lfsr[2k+1:2k] as 00->4'b1110, 01->4'b1101, 10->4'b1011, 11->4'b0111.
- IDLE: display 0. On start go to SHOW: latch the mapped sequence into sequence_gen, clear sec_cnt.
- SHOW:
  - display 8'h10.
  - sec_cnt increments on each one_sec.
  - When sec_cnt == SHOW_SECS, go to GUARD.
  - button_next and button_move are ignored.
- GUARD:
  - display 8'h10.
  - Counts GUARD_CYCLES clk cycles, then goes to ENTRY with digit_idx=0, cur=4'b1110, mismatch=0.
  - Buttons are ignored.
- ENTRY: display 8'h10.
  - button_move alone: cur rotates 1110->1101->1011->0111->1110.
  - button_next (wins if it arrives in the same cycle as button_move):
    - mismatch |= (cur != nibble[15-4*digit_idx -: 4]).
    - cur resets to 4'b1110.
    - digit_idx increments.
    - On the 4th next, go to RESULT with the final mismatch value.
- RESULT: one cycle, display 8'h00.
  - Match: solved=1, go to DONE.
  - Mismatch: strikes+1 and strike_pulse=1.
    - If the new strikes == MAX_STRIKES, exploded=1 and go to DONE.
    - Otherwise go to SHOW with a freshly latched sequence_gen.
- DONE: display 8'h00. Terminal; only reset leaves it.
- start outside IDLE is ignored.
- strikes saturates at MAX_STRIKES.
- A one_sec pulse coinciding with the SHOW-entry cycle is counted.
- Reset mid-puzzle returns to IDLE within one cycle. display drops to 0, so the display block returns to its init state.

Optional Feature:
- SEQ_DEBUG_FIXED_EN defined: every latch into sequence_gen loads FIXED_SEQ. The LFSR still runs.
- Not defined: the LFSR-derived sequence is used.

Decomposition:
- Package seq_puzzle_pkg holds:
  - the state enum;
  - the one-cold digit constants DIG_0..DIG_3 (4'b1110, 4'b1101, 4'b1011, 4'b0111);
  - DISP_SEQ = 8'h10 and DISP_IDLE = 8'h00;
  - LFSR_MASK = 16'hB400;
  - a digit-rotate function.
- One sub-module: seq_lfsr16, the free-running Galois LFSR with seed parameter.

Test Plan:
- Pass (SEQ_DEBUG_FIXED_EN, FIXED_SEQ=16'hE7BD): start; 2 one_sec; wait 4 cycles; entry moves per digit 0,3,2,1, each followed by next -> solved=1, strikes=0, display back to 8'h00 after RESULT.
- Strike and retry: same setup, enter 0,0,0,0 moves -> strike_pulse for one cycle, strikes=1, display 8'h10 again, sequence_gen reloaded, then the correct entry gives solved=1.
- Explode: three wrong attempts -> exploded=1 on the third RESULT, strikes=3, button pulses in DONE have no effect.
- Ignore window: button_next and button_move pulses during SHOW and GUARD -> digit_idx stays 0, no comparison occurs.
- Simultaneous move+next on digit 0 with cur=4'b1110 and expected 4'b1110 -> treated as next only, digit matches.
- Mid-entry reset after 2 digits -> next cycle all outputs at reset values, LFSR=LFSR_SEED, start restarts cleanly.

Source files
------------

// File: rtl/seq_puzzle_pkg.sv
// Shared types, constants and helpers for the sequence-memory puzzle master.
package seq_puzzle_pkg;

   localparam int unsigned SEQ_W  = 16;
   localparam int unsigned DIG_W  = 4;
   localparam int unsigned DISP_W = 8;
   localparam int unsigned STK_W  = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHOW,
      ST_GUARD,
      ST_ENTRY,
      ST_RESULT,
      ST_DONE
   } state_t;

   localparam logic [DIG_W-1:0] DIG_0 = 4'b1110;
   localparam logic [DIG_W-1:0] DIG_1 = 4'b1101;
   localparam logic [DIG_W-1:0] DIG_2 = 4'b1011;
   localparam logic [DIG_W-1:0] DIG_3 = 4'b0111;

   localparam logic [DISP_W-1:0] DISP_SEQ  = 8'h10;
   localparam logic [DISP_W-1:0] DISP_IDLE = 8'h00;

   localparam logic [SEQ_W-1:0] LFSR_MASK = 16'hB400;

   // Next digit shown when the player presses move.
   function automatic logic [DIG_W-1:0] rotate_digit(input logic [DIG_W-1:0] cur);
      logic [DIG_W-1:0] nxt;
      case (cur)
         DIG_0:   nxt = DIG_1;
         DIG_1:   nxt = DIG_2;
         DIG_2:   nxt = DIG_3;
         default: nxt = DIG_0;
      endcase
      return nxt;
   endfunction

   function automatic logic [DIG_W-1:0] code_to_digit(input logic [1:0] code);
      logic [DIG_W-1:0] dig;
      case (code)
         2'b00:   dig = DIG_0;
         2'b01:   dig = DIG_1;
         2'b10:   dig = DIG_2;
         default: dig = DIG_3;
      endcase
      return dig;
   endfunction

   // Two LFSR bits per digit; nibble k takes bits [2k+1:2k].
   function automatic logic [SEQ_W-1:0] map_sequence(input logic [7:0] bits);
      logic [SEQ_W-1:0] seq;
      seq = '0;
      for (int k = 0; k < 4; k++) begin
         seq[4*k +: 4] = code_to_digit(bits[2*k +: 2]);
      end
      return seq;
   endfunction

   // Digit idx 0 is the most significant nibble.
   function automatic logic [DIG_W-1:0] nibble_at(input logic [SEQ_W-1:0] seq,
                                                  input logic [1:0] idx);
      logic [DIG_W-1:0] nib;
      case (idx)
         2'd0:    nib = seq[15:12];
         2'd1:    nib = seq[11:8];
         2'd2:    nib = seq[7:4];
         default: nib = seq[3:0];
      endcase
      return nib;
   endfunction

endpackage

// File: rtl/seq_puzzle_master_if.sv
// Puzzle master bus: player/timing inputs and puzzle status outputs.
interface seq_puzzle_master_if;
   import seq_puzzle_pkg::*;

   logic              start;
   logic              one_sec;
   logic              button_move;
   logic              button_next;
   logic [DISP_W-1:0] display;
   logic [SEQ_W-1:0]  sequence_gen;
   logic              solved;
   logic              exploded;
   logic [STK_W-1:0]  strikes;
   logic              strike_pulse;

   modport master (
      input  start, one_sec, button_move, button_next,
      output display, sequence_gen, solved, exploded, strikes, strike_pulse
   );

   modport slave (
      output start, one_sec, button_move, button_next,
      input  display, sequence_gen, solved, exploded, strikes, strike_pulse
   );

endinterface

// File: rtl/seq_lfsr16.sv
// Free-running 16-bit Galois LFSR; only the low byte feeds the digit mapping.
module seq_lfsr16
   import seq_puzzle_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic       clk,
   input  logic       reset,
   output logic [7:0] low_bits
);

   // An all-zero seed would lock the register, so it is replaced by 1.
   localparam logic [15:0] RESET_VAL = (SEED == 16'h0000) ? 16'h0001 : SEED;

   logic [15:0] lfsr;

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr <= RESET_VAL;
      end else begin
         lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
      end
   end

   assign low_bits = lfsr[7:0];

endmodule

// File: rtl/seq_puzzle_master.sv
// Sequence-memory puzzle master: shows a random sequence, shadows entry, scores it.
// Define SEQ_DEBUG_FIXED_EN to load FIXED_SEQ instead of the LFSR-derived sequence.
module seq_puzzle_master
   import seq_puzzle_pkg::*;
#(
   parameter logic [15:0] LFSR_SEED    = 16'hACE1,
   parameter int unsigned SHOW_SECS    = 2,
   parameter int unsigned GUARD_CYCLES = 4,
   parameter int unsigned MAX_STRIKES  = 3
`ifdef SEQ_DEBUG_FIXED_EN
   ,
   parameter logic [15:0] FIXED_SEQ    = 16'hE7BD
`endif
) (
   input  logic                clk,
   input  logic                reset,
   seq_puzzle_master_if.master bus
);

   localparam int unsigned SEC_W     = $clog2(SHOW_SECS + 1);
   localparam int unsigned GRD_W     = $clog2(GUARD_CYCLES + 1);
   localparam int unsigned STK_INC_W = STK_W + 1;

   state_t            state, state_next;
   logic [SEC_W-1:0]  sec_cnt, sec_cnt_next;
   logic [GRD_W-1:0]  guard_cnt, guard_cnt_next;
   logic [1:0]        digit_idx, digit_idx_next;
   logic [DIG_W-1:0]  cur, cur_next;
   logic              mismatch, mismatch_next;

   logic [DISP_W-1:0] display_next;
   logic [SEQ_W-1:0]  seq_next;
   logic              solved_next;
   logic              exploded_next;
   logic [STK_W-1:0]  strikes_next;
   logic              strike_pulse_next;

   logic [7:0]           lfsr_bits;
   logic [SEQ_W-1:0]     seq_load;
   logic [STK_INC_W-1:0] strikes_inc;
   logic                 strikes_hit_max;
   logic                 mismatch_acc;

   seq_lfsr16 #(
      .SEED(LFSR_SEED)
   ) u_lfsr (
      .clk      (clk),
      .reset    (reset),
      .low_bits (lfsr_bits)
   );

`ifdef SEQ_DEBUG_FIXED_EN
   assign seq_load = FIXED_SEQ;
`else
   assign seq_load = map_sequence(lfsr_bits);
`endif

   assign strikes_inc     = {1'b0, bus.strikes} + STK_INC_W'(1);
   assign strikes_hit_max = (strikes_inc >= STK_INC_W'(MAX_STRIKES));
   assign mismatch_acc    = mismatch | (cur != nibble_at(bus.sequence_gen, digit_idx));

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= ST_IDLE;
         sec_cnt          <= '0;
         guard_cnt        <= '0;
         digit_idx        <= '0;
         cur              <= DIG_0;
         mismatch         <= 1'b0;
         bus.display      <= DISP_IDLE;
         bus.sequence_gen <= '0;
         bus.solved       <= 1'b0;
         bus.exploded     <= 1'b0;
         bus.strikes      <= '0;
         bus.strike_pulse <= 1'b0;
      end else begin
         state            <= state_next;
         sec_cnt          <= sec_cnt_next;
         guard_cnt        <= guard_cnt_next;
         digit_idx        <= digit_idx_next;
         cur              <= cur_next;
         mismatch         <= mismatch_next;
         bus.display      <= display_next;
         bus.sequence_gen <= seq_next;
         bus.solved       <= solved_next;
         bus.exploded     <= exploded_next;
         bus.strikes      <= strikes_next;
         bus.strike_pulse <= strike_pulse_next;
      end
   end

   always_comb begin
      state_next        = state;
      sec_cnt_next      = sec_cnt;
      guard_cnt_next    = guard_cnt;
      digit_idx_next    = digit_idx;
      cur_next          = cur;
      mismatch_next     = mismatch;
      seq_next          = bus.sequence_gen;
      solved_next       = bus.solved;
      exploded_next     = bus.exploded;
      strikes_next      = bus.strikes;
      strike_pulse_next = 1'b0;

      case (state)
         ST_IDLE: begin
            // A one_sec landing on the entry cycle still counts toward the show time.
            if (bus.start) begin
               state_next   = ST_SHOW;
               seq_next     = seq_load;
               sec_cnt_next = SEC_W'(bus.one_sec);
            end
         end
         ST_SHOW: begin
            if (sec_cnt == SEC_W'(SHOW_SECS)) begin
               state_next     = ST_GUARD;
               guard_cnt_next = '0;
            end else if (bus.one_sec) begin
               sec_cnt_next = sec_cnt + SEC_W'(1);
            end
         end
         ST_GUARD: begin
            if (guard_cnt == GRD_W'(GUARD_CYCLES - 1)) begin
               state_next     = ST_ENTRY;
               digit_idx_next = '0;
               cur_next       = DIG_0;
               mismatch_next  = 1'b0;
            end else begin
               guard_cnt_next = guard_cnt + GRD_W'(1);
            end
         end
         ST_ENTRY: begin
            // next takes priority over a coincident move.
            if (bus.button_next) begin
               cur_next      = DIG_0;
               mismatch_next = mismatch_acc;
               if (digit_idx == 2'd3) begin
                  state_next = ST_RESULT;
               end else begin
                  digit_idx_next = digit_idx + 2'd1;
               end
            end else if (bus.button_move) begin
               cur_next = rotate_digit(cur);
            end
         end
         ST_RESULT: begin
            if (!mismatch) begin
               solved_next = 1'b1;
               state_next  = ST_DONE;
            end else begin
               strikes_next      = strikes_hit_max ? STK_W'(MAX_STRIKES) : STK_W'(strikes_inc);
               strike_pulse_next = 1'b1;
               if (strikes_hit_max) begin
                  exploded_next = 1'b1;
                  state_next    = ST_DONE;
               end else begin
                  state_next   = ST_SHOW;
                  seq_next     = seq_load;
                  sec_cnt_next = SEC_W'(bus.one_sec);
               end
            end
         end
         ST_DONE: begin
            state_next = ST_DONE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      display_next = (state_next == ST_SHOW || state_next == ST_GUARD || state_next == ST_ENTRY)
                     ? DISP_SEQ : DISP_IDLE;
   end

endmodule

// File: tb/tb_seq_puzzle_master.sv
// Randomized bench for seq_puzzle_master with a phase-level behavioural model.
module tb_seq_puzzle_master;

   localparam logic [15:0] SEED         = 16'hACE1;
   localparam int          SHOW_SECS    = 2;
   localparam int          GUARD_CYCLES = 4;
   localparam int          MAX_STRIKES  = 3;
`ifdef SEQ_DEBUG_FIXED_EN
   localparam logic [15:0] FIRST_SEQ    = 16'hE7BD;
`else
   localparam logic [15:0] FIRST_SEQ    = 16'h7BED;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;

   seq_puzzle_master_if bus();

   seq_puzzle_master #(
      .LFSR_SEED    (SEED),
      .SHOW_SECS    (SHOW_SECS),
      .GUARD_CYCLES (GUARD_CYCLES),
      .MAX_STRIKES  (MAX_STRIKES)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at time %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef enum int {M_IDLE, M_SHOW, M_GUARD, M_ENTRY, M_RESULT, M_DONE} phase_t;

   phase_t      ph = M_IDLE;
   bit          m_valid = 1'b0;
   int          secs_seen, guard_left, cur_pos, m_strikes;
   int          entered[$];
   logic [15:0] m_lfsr, m_seq, prev_lfsr;
   logic [7:0]  m_display;
   logic        m_solved, m_exploded, m_pulse;
   bit          match;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
   endfunction

   function automatic logic [3:0] digit_for(input int pos);
      logic [3:0] d;
      d = 4'hF;
      d[pos] = 1'b0;
      return d;
   endfunction

   function automatic logic [15:0] load_value(input logic [15:0] v);
`ifdef SEQ_DEBUG_FIXED_EN
      return (v & 16'h0000) | 16'hE7BD;
`else
      logic [15:0] s;
      s = 16'h0000;
      for (int k = 0; k < 4; k++) begin
         s = s | (16'(digit_for(int'((v >> (2 * k)) & 16'h3))) << (4 * k));
      end
      return s;
`endif
   endfunction

   // Position of the zero bit of the digit entered i-th (0 = first, most significant).
   function automatic int want_pos(input logic [15:0] seq, input int i);
      logic [15:0] sh;
      sh = seq >> (12 - 4 * i);
      for (int p = 0; p < 4; p++) begin
         if (sh[p] == 1'b0) return p;
      end
      return -1;
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         if (reset) begin
            ph         = M_IDLE;
            m_lfsr     = (SEED == 16'h0) ? 16'h0001 : SEED;
            m_seq      = 16'h0000;
            m_display  = 8'h00;
            m_solved   = 1'b0;
            m_exploded = 1'b0;
            m_pulse    = 1'b0;
            m_strikes  = 0;
            entered.delete();
            m_valid    = 1'b1;
         end else begin
            prev_lfsr = m_lfsr;
            m_lfsr    = lfsr_step(m_lfsr);
            m_pulse   = 1'b0;
            case (ph)
               M_IDLE: if (bus.start) begin
                  m_seq     = load_value(prev_lfsr);
                  secs_seen = int'(bus.one_sec);
                  ph        = M_SHOW;
               end
               M_SHOW: begin
                  if (secs_seen == SHOW_SECS) begin
                     ph         = M_GUARD;
                     guard_left = GUARD_CYCLES;
                  end else if (bus.one_sec) begin
                     secs_seen++;
                  end
               end
               M_GUARD: begin
                  guard_left--;
                  if (guard_left == 0) begin
                     ph      = M_ENTRY;
                     cur_pos = 0;
                     entered.delete();
                  end
               end
               M_ENTRY: begin
                  if (bus.button_next) begin
                     entered.push_back(cur_pos);
                     cur_pos = 0;
                     if (entered.size() == 4) ph = M_RESULT;
                  end else if (bus.button_move) begin
                     cur_pos = (cur_pos + 1) % 4;
                  end
               end
               M_RESULT: begin
                  match = 1'b1;
                  for (int i = 0; i < 4; i++) begin
                     if (entered[i] != want_pos(m_seq, i)) match = 1'b0;
                  end
                  if (match) begin
                     m_solved = 1'b1;
                     ph       = M_DONE;
                  end else begin
                     if (m_strikes < MAX_STRIKES) m_strikes++;
                     m_pulse = 1'b1;
                     if (m_strikes == MAX_STRIKES) begin
                        m_exploded = 1'b1;
                        ph         = M_DONE;
                     end else begin
                        m_seq     = load_value(prev_lfsr);
                        secs_seen = int'(bus.one_sec);
                        ph        = M_SHOW;
                     end
                  end
               end
               default: ;
            endcase
            m_display = (ph == M_SHOW || ph == M_GUARD || ph == M_ENTRY) ? 8'h10 : 8'h00;
         end
      end
   end

   // Every-cycle comparison against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (m_valid) begin
            check("display",      16'(bus.display),      16'(m_display));
            check("sequence_gen", bus.sequence_gen,      m_seq);
            check("solved",       16'(bus.solved),       16'(m_solved));
            check("exploded",     16'(bus.exploded),     16'(m_exploded));
            check("strikes",      16'(bus.strikes),      16'(m_strikes));
            check("strike_pulse", 16'(bus.strike_pulse), 16'(m_pulse));
            check("lfsr",         dut.u_lfsr.lfsr,       m_lfsr);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input bit s, input bit os, input bit mv, input bit nx);
      bus.start       = s;
      bus.one_sec     = os;
      bus.button_move = mv;
      bus.button_next = nx;
      @(negedge clk);
      bus.start       = 1'b0;
      bus.one_sec     = 1'b0;
      bus.button_move = 1'b0;
      bus.button_next = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset_and_start();
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      idle($urandom_range(0, 3));
      drive(1'b1, $urandom_range(0, 3) == 0, 1'b0, 1'b0);
   endtask

   // Buttons, start and one_sec noise during show/guard; entry must still open cleanly.
   task automatic run_to_entry();
      int budget;
      budget = 400;
      while (ph != M_ENTRY && budget > 0) begin
         budget--;
         if (ph == M_SHOW || ph == M_GUARD)
            drive($urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
         else
            idle(1);
      end
      checks++;
      if (ph != M_ENTRY) begin
         errors++;
         $display("FAIL entry_timeout: phase %0d required %0d", int'(ph), int'(M_ENTRY));
      end
   endtask

   task automatic enter_digit(input int target);
      for (int m = 0; m < target; m++) begin
         idle($urandom_range(0, 2));
         drive(1'b0, $urandom_range(0, 3) == 0, 1'b1, 1'b0);
      end
      idle($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) drive(1'b0, 1'b0, 1'b1, 1'b1);
      else                           drive(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic attempt(input bit correct);
      int tgt[4];
      int w;
      for (int i = 0; i < 4; i++) tgt[i] = want_pos(m_seq, i);
      if (!correct) begin
         w = $urandom_range(0, 3);
         tgt[w] = (tgt[w] + $urandom_range(1, 3)) % 4;
      end
      for (int i = 0; i < 4; i++) enter_digit(tgt[i]);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time %0t exceeded", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start       = 1'b0;
      bus.one_sec     = 1'b0;
      bus.button_move = 1'b0;
      bus.button_next = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);

      check("rst_display", 16'(bus.display), 16'h0000);
      check("rst_seq",     bus.sequence_gen, 16'h0000);
      check("rst_strikes", 16'(bus.strikes), 16'h0000);
      check("rst_lfsr",    dut.u_lfsr.lfsr,  16'hACE1);

      // Correct first attempt, start in the very first cycle out of reset.
      reset = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      check("first_seq",   bus.sequence_gen, FIRST_SEQ);
      check("first_disp",  16'(bus.display), 16'h0010);
      check("lfsr_step1",  dut.u_lfsr.lfsr,  16'hE270);
      run_to_entry();
      attempt(1'b1);
      idle(2);
      check("pass_solved",  16'(bus.solved),  16'h0001);
      check("pass_strikes", 16'(bus.strikes), 16'h0000);
      check("pass_display", 16'(bus.display), 16'h0000);

      // One strike, then retry and solve.
      do_reset_and_start();
      run_to_entry();
      attempt(1'b0);
      idle(1);
      check("strike_pulse_hi", 16'(bus.strike_pulse), 16'h0001);
      check("strike_count",    16'(bus.strikes),      16'h0001);
      check("strike_display",  16'(bus.display),      16'h0010);
      idle(1);
      check("strike_pulse_lo", 16'(bus.strike_pulse), 16'h0000);
      run_to_entry();
      attempt(1'b1);
      idle(2);
      check("retry_solved", 16'(bus.solved), 16'h0001);

      // Three failures explode; buttons in DONE are inert.
      do_reset_and_start();
      for (int a = 0; a < 3; a++) begin
         run_to_entry();
         attempt(1'b0);
      end
      idle(1);
      check("boom_exploded", 16'(bus.exploded), 16'h0001);
      check("boom_strikes",  16'(bus.strikes),  16'h0003);
      repeat (12) drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                        $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      check("done_exploded", 16'(bus.exploded), 16'h0001);
      check("done_solved",   16'(bus.solved),   16'h0000);
      check("done_display",  16'(bus.display),  16'h0000);

      // Reset in the middle of entry, then a clean restart.
      do_reset_and_start();
      run_to_entry();
      enter_digit(want_pos(m_seq, 0));
      enter_digit(want_pos(m_seq, 1));
      reset = 1'b1;
      idle(1);
      check("midrst_display", 16'(bus.display), 16'h0000);
      check("midrst_seq",     bus.sequence_gen, 16'h0000);
      check("midrst_lfsr",    dut.u_lfsr.lfsr,  16'hACE1);
      reset = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      run_to_entry();
      attempt(1'b1);
      idle(2);
      check("restart_solved", 16'(bus.solved), 16'h0001);

      // Random games until each ends.
      for (int r = 0; r < 6; r++) begin
         do_reset_and_start();
         for (int a = 0; a < 4 && ph != M_DONE; a++) begin
            run_to_entry();
            attempt($urandom_range(0, 2) == 0);
            idle(2);
         end
      end

      idle(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
